// File: rtl/mips_pkg.sv
// Shared MIPS core constants and basic datapath types.
package mips_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/register_file.sv
// 2R/1W general-purpose register file: combinational reads with optional
// write-through bypass, synchronous write and synchronous clear.
module register_file #(
   parameter int unsigned DATA_W    = mips_pkg::DATA_W,
   parameter int unsigned ADDR_W    = mips_pkg::REG_ADDR_W,
   parameter bit          R0_ZERO   = 1'b0,
   parameter bit          WR_BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              regwrite
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_wr_en;
   logic              w_wr_keep;

   // A write only lands when not in reset and not targeting a hardwired $zero.
   assign w_wr_keep = !(R0_ZERO && (wa == '0));
   assign w_wr_en   = regwrite && !rst && w_wr_keep;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[wa] <= wd;
      end
   end

   // Read mux: $zero override first, then same-cycle forward, then storage.
   function automatic logic [DATA_W-1:0] f_read(
      input logic [ADDR_W-1:0] ra,
      input logic [DATA_W-1:0] stored,
      input logic              fwd_en,
      input logic [ADDR_W-1:0] fwd_addr,
      input logic [DATA_W-1:0] fwd_data
   );
      logic [DATA_W-1:0] v;
      v = stored;
      if (R0_ZERO && (ra == '0)) begin
         v = '0;
      end else if (WR_BYPASS && fwd_en && (ra == fwd_addr)) begin
         v = fwd_data;
      end
      return v;
   endfunction

   logic w_fwd_en;
   assign w_fwd_en = regwrite && !rst;

   always_comb begin
      rd1 = f_read(ra1, r_mem[ra1], w_fwd_en, wa, wd);
      rd2 = f_read(ra2, r_mem[ra2], w_fwd_en, wa, wd);
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: two register files (plain reg 0 and $zero reg 0) on
// shared stimulus, compared against an array-based reference model.
module tb_register_file;
   import mips_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   logic      regwrite;
   reg_addr_t ra1, ra2, wa;
   word_t     wd;
   word_t     rd1, rd2, rd1_z, rd2_z;

   always #5 clk = ~clk;

   register_file #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W), .R0_ZERO(1'b0), .WR_BYPASS(1'b1)) u_dut (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .wa(wa), .wd(wd), .regwrite(regwrite)
   );

   register_file #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W), .R0_ZERO(1'b1), .WR_BYPASS(1'b1)) u_dut_z (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
      .wa(wa), .wd(wd), .regwrite(regwrite)
   );

   word_t       m_mem [NUM_REGS];
   word_t       z_mem [NUM_REGS];
   word_t       fill  [NUM_REGS];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input word_t got, input word_t exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected read value in the current cycle for either flavour of reg 0.
   function automatic word_t ref_rd(input bit zero, input reg_addr_t ra);
      if (zero && ra == 0) return '0;
      if (regwrite === 1'b1 && rst === 1'b0 && ra == wa) return wd;
      return zero ? z_mem[ra] : m_mem[ra];
   endfunction

   task automatic drive(input logic r, input logic we, input reg_addr_t a_w,
                        input word_t d, input reg_addr_t a1, input reg_addr_t a2);
      rst = r; regwrite = we; wa = a_w; wd = d; ra1 = a1; ra2 = a2;
   endtask

   // One clock: optionally check reads at negedge, then advance the model.
   task automatic step(input bit check);
      @(negedge clk);
      if (check) begin
         chk("rd1",   rd1,   ref_rd(1'b0, ra1));
         chk("rd2",   rd2,   ref_rd(1'b0, ra2));
         chk("rd1_z", rd1_z, ref_rd(1'b1, ra1));
         chk("rd2_z", rd2_z, ref_rd(1'b1, ra2));
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            m_mem[i] = '0;
            z_mem[i] = '0;
         end
      end else if (regwrite) begin
         m_mem[wa] = wd;
         if (wa != 0) z_mem[wa] = wd;
      end
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, '0, '0, '0, '0);
      @(posedge clk); #1;
      step(1'b0);

      // Reset state: every register reads zero.
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         drive(1'b0, 1'b0, '0, '0, reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i));
         #1 chk("reset_state", rd1, 32'h0);
         step(1'b1);
      end

      // Fill all 32 registers with random data.
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         fill[i] = $urandom;
         drive(1'b0, 1'b1, reg_addr_t'(i), fill[i], reg_addr_t'(i), reg_addr_t'((i + 1) % NUM_REGS));
         step(1'b1);
      end

      // Sweep even/odd addresses with write data undriven and writes off.
      for (int i = 0; i < int'(NUM_REGS) / 2; i++) begin
         drive(1'b0, 1'b0, 'x, 'x, reg_addr_t'(2 * i), reg_addr_t'(2 * i + 1));
         #1;
         chk("fill_rd1", rd1, fill[2 * i]);
         chk("fill_rd2", rd2, fill[2 * i + 1]);
         chk("fill_rd1_z", rd1_z, (i == 0) ? 32'h0 : fill[2 * i]);
         step(1'b1);
      end

      // Reset clears a written register.
      drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
      step(1'b1);
      drive(1'b1, 1'b0, '0, '0, 5'd5, 5'd5);
      step(1'b1);
      drive(1'b0, 1'b0, '0, '0, 5'd5, 5'd5);
      #1 chk("reset_rd1", rd1, 32'h0);
      step(1'b1);

      // Write disable leaves reg 7 untouched.
      drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd0);
      step(1'b1);
      drive(1'b0, 1'b0, 5'd7, 32'h12345678, 5'd7, 5'd7);
      step(1'b1);
      #1 chk("wr_disable", rd1, 32'hA5A5A5A5);

      // Same-cycle bypass on both ports, then persistence.
      drive(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
      #1;
      chk("bypass_rd1", rd1, 32'hCAFEF00D);
      chk("bypass_rd2", rd2, 32'hCAFEF00D);
      chk("bypass_rd2_z", rd2_z, 32'hCAFEF00D);
      step(1'b1);
      drive(1'b0, 1'b0, '0, '0, 5'd9, 5'd9);
      #1 chk("bypass_hold", rd1, 32'hCAFEF00D);
      step(1'b1);

      // Register 0: hardwired zero versus ordinary storage.
      drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      #1;
      chk("r0z_bypass", rd1_z, 32'h0);
      chk("r0_bypass",  rd1,   32'hFFFFFFFF);
      step(1'b1);
      drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0);
      #1;
      chk("r0z_read", rd1_z, 32'h0);
      chk("r0_read",  rd1,   32'hFFFFFFFF);
      step(1'b1);

      // Reset wins over a simultaneous write.
      drive(1'b0, 1'b1, 5'd3, 32'h77, 5'd1, 5'd1);
      step(1'b1);
      drive(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
      step(1'b1);
      drive(1'b0, 1'b0, '0, '0, 5'd3, 5'd3);
      #1;
      chk("collision",   rd1,   32'h0);
      chk("collision_z", rd1_z, 32'h0);
      step(1'b1);

      // Random traffic with biased address collisions.
      for (int n = 0; n < 400; n++) begin
         reg_addr_t a_w, a1, a2;
         a_w = reg_addr_t'($urandom_range(NUM_REGS - 1));
         a1  = ($urandom_range(3) == 0) ? a_w : reg_addr_t'($urandom_range(NUM_REGS - 1));
         a2  = ($urandom_range(3) == 0) ? a_w : reg_addr_t'($urandom_range(NUM_REGS - 1));
         drive(($urandom_range(49) == 0), 1'($urandom_range(1)), a_w, $urandom, a1, a2);
         step(1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
